// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the cache-line / BRAM transfer path.
//   - Default geometry of the line controller (word width, words per line,
//     address widths, BRAM read latency).
//   - WORD_IDX_W: bits needed to index a word inside a line.
//   - state_e: line controller FSM encoding.
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_LINE_WORDS     = 4;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_MEM_ADDR_WIDTH = 10;
    localparam int DEF_READ_LATENCY   = 2;

    localparam int WORD_IDX_W = $clog2(DEF_LINE_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ_ISSUE = 3'd2,
        ST_READ_DRAIN = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

endpackage

// File: rtl/mem_line_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_line_ctrl_if
// Line request / response bus between the cache miss-writeback logic
// (master) and the line controller (slave).
//   req_valid / req_ready : request handshake
//   req_we                : 1 = writeback line, 0 = refill line
//   req_addr              : byte address of the line
//   req_wdata             : writeback line, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : refill line, same packing as req_wdata
//   busy                  : transfer in progress
// ---------------------------------------------------------------------------
interface mem_line_ctrl_if
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                             req_valid;
    logic                             req_ready;
    logic                             req_we;
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic [LINE_WORDS*DATA_WIDTH-1:0] req_wdata;
    logic                             resp_valid;
    logic [LINE_WORDS*DATA_WIDTH-1:0] resp_rdata;
    logic                             busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
    );

endinterface

// File: rtl/mem_rd_pipe.sv
// ---------------------------------------------------------------------------
// mem_rd_pipe
// Tracks BRAM reads in flight. A read issued in cycle c (in_valid/in_idx)
// comes out as a capture strobe (out_valid/out_idx) in cycle c+LATENCY,
// which is the cycle its data is on mem_dout.
//   clk, rst  : clock, synchronous active-high reset (clears valid bits)
//   in_valid  : a read is being issued this cycle
//   in_idx    : word index of that read inside the line
//   out_valid : mem_dout holds a tracked word this cycle
//   out_idx   : word index of that word
// ---------------------------------------------------------------------------
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int LATENCY = DEF_READ_LATENCY,
    parameter int IDX_W   = WORD_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LATENCY-1:0] vld_q;
    logic [IDX_W-1:0]   idx_q [LATENCY];

    // Valid bits are reset so that reads in flight at reset are forgotten.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // NOTE: the index stages carry no reset; they are only looked at when the
    // matching valid bit is set, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        idx_q[0] <= in_idx;
        for (int k = 1; k < LATENCY; k++) begin
            idx_q[k] <= idx_q[k-1];
        end
    end

    assign out_valid = vld_q[LATENCY-1];
    assign out_idx   = idx_q[LATENCY-1];

endmodule

// File: rtl/mem_line_ctrl.sv
// ---------------------------------------------------------------------------
// mem_line_ctrl
// Turns one cache-line request (refill read or dirty writeback) into
// LINE_WORDS consecutive word accesses on one BRAM port, absorbs the BRAM
// read latency and returns the assembled line with a one-cycle pulse.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : line request/response bus (slave side)
//   mem_addr   : BRAM word address
//   mem_din    : BRAM write data
//   mem_en     : BRAM port enable
//   mem_we     : BRAM write enable
//   mem_regce  : BRAM output-register enable (always on)
//   mem_rst    : BRAM output-register reset (unused, held low)
//   mem_dout   : BRAM read data
// ---------------------------------------------------------------------------
module mem_line_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int LINE_WORDS     = DEF_LINE_WORDS,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int READ_LATENCY   = DEF_READ_LATENCY
) (
    input  logic                      clk,
    input  logic                      rst,
    mem_line_ctrl_if.slave            bus,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_din,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic                      mem_regce,
    output logic                      mem_rst,
    input  logic [DATA_WIDTH-1:0]     mem_dout
);

    localparam int               IDX_W    = $clog2(LINE_WORDS);
    localparam int               LINE_W   = LINE_WORDS * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                cnt_q;
    logic [MEM_ADDR_WIDTH-IDX_W-1:0] line_addr_q;
    logic [LINE_W-1:0]               wline_q;
    logic [LINE_W-1:0]               rbuf_q, rbuf_next;
    logic [LINE_W-1:0]               resp_rdata_q;

    logic             accept;
    logic             issue;
    logic             cap_valid;
    logic [IDX_W-1:0] cap_idx;
    logic             cap_last;

    logic req_ready, resp_valid, busy;

    // Byte/word-offset bits and the bits above the BRAM range never reach
    // the BRAM; the line base keeps only the line-number bits.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2],
                           bus.req_addr[IDX_W+1:0]};

    assign accept   = (state_q == ST_IDLE) && bus.req_valid;
    assign cap_last = cap_valid && (cap_idx == LAST_IDX);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            // Counts issue cycles and wraps to 0 after the last word.
            if (state_q == ST_WRITE || state_q == ST_READ_ISSUE) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (bus.req_valid) state_d = bus.req_we ? ST_WRITE : ST_READ_ISSUE;
            ST_WRITE:      if (cnt_q == LAST_IDX) state_d = ST_DONE;
            ST_READ_ISSUE: if (cnt_q == LAST_IDX) state_d = ST_READ_DRAIN;
            ST_READ_DRAIN: if (cap_last) state_d = ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        issue      = 1'b0;
        unique case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_WRITE: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {line_addr_q, cnt_q};
                mem_din  = wline_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
            end
            ST_READ_ISSUE: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = {line_addr_q, cnt_q};
                issue    = 1'b1;
            end
            ST_READ_DRAIN: busy = 1'b1;
            ST_DONE:       resp_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- request capture ----------------
    always_ff @(posedge clk) begin
        if (accept) begin
            line_addr_q <= bus.req_addr[MEM_ADDR_WIDTH+1:IDX_W+2];
            wline_q     <= bus.req_wdata;
        end
    end

    // ---------------- read tracking and capture ----------------
    mem_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .IDX_W   (IDX_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_idx    (cnt_q),
        .out_valid (cap_valid),
        .out_idx   (cap_idx)
    );

    always_comb begin
        rbuf_next = rbuf_q;
        if (cap_valid) begin
            rbuf_next[cap_idx*DATA_WIDTH +: DATA_WIDTH] = mem_dout;
        end
    end

    // Words are assembled in a scratch buffer; the visible line only changes
    // when a refill completes, so a writeback or an aborted refill leaves it.
    always_ff @(posedge clk) begin
        rbuf_q <= rbuf_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata_q <= '0;
        end else if (state_q == ST_READ_DRAIN && cap_last) begin
            resp_rdata_q <= rbuf_next;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.busy       = busy;

    assign mem_regce = 1'b1;
    assign mem_rst   = 1'b0;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_line_ctrl
// Two controllers share clk/rst: dut2 (READ_LATENCY=2) and dut1
// (READ_LATENCY=1), each with its own BRAM model. Requests go to the one
// selected by `cur`; outputs are viewed through a mux on the same select.
// A reference memory per controller holds the expected BRAM contents.
// ---------------------------------------------------------------------------
module tb_mem_line_ctrl;

    localparam int LW = 4;
    localparam int DW = 32;

    typedef logic [LW*DW-1:0] line_t;

    typedef struct {
        int          sel;
        bit          we;
        logic [31:0] addr;
        line_t       wdata;
        logic [9:0]  exp_base;
        int          exp_resp;
        line_t       exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cur = 2;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    line_t       req_wdata;
    bit          preload = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_line_ctrl_if #(.DATA_WIDTH(DW), .LINE_WORDS(LW), .ADDR_WIDTH(32)) bus2 ();
    mem_line_ctrl_if #(.DATA_WIDTH(DW), .LINE_WORDS(LW), .ADDR_WIDTH(32)) bus1 ();

    assign bus2.req_valid = req_valid && (cur == 2);
    assign bus1.req_valid = req_valid && (cur == 1);
    assign bus2.req_we    = req_we;
    assign bus1.req_we    = req_we;
    assign bus2.req_addr  = req_addr;
    assign bus1.req_addr  = req_addr;
    assign bus2.req_wdata = req_wdata;
    assign bus1.req_wdata = req_wdata;

    logic [9:0]    m2_addr, m1_addr;
    logic [DW-1:0] m2_din, m1_din, m2_dout, m1_dout;
    logic          m2_en, m1_en, m2_we, m1_we, m2_regce, m1_regce, m2_rst, m1_rst;

    mem_line_ctrl #(.DATA_WIDTH(DW), .LINE_WORDS(LW), .ADDR_WIDTH(32),
                    .MEM_ADDR_WIDTH(10), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2),
        .mem_addr(m2_addr), .mem_din(m2_din), .mem_en(m2_en), .mem_we(m2_we),
        .mem_regce(m2_regce), .mem_rst(m2_rst), .mem_dout(m2_dout)
    );

    mem_line_ctrl #(.DATA_WIDTH(DW), .LINE_WORDS(LW), .ADDR_WIDTH(32),
                    .MEM_ADDR_WIDTH(10), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .mem_addr(m1_addr), .mem_din(m1_din), .mem_en(m1_en), .mem_we(m1_we),
        .mem_regce(m1_regce), .mem_rst(m1_rst), .mem_dout(m1_dout)
    );

    // ---------------- BRAM models ----------------
    logic [DW-1:0] bram2 [1024];
    logic [DW-1:0] bram1 [1024];
    logic [DW-1:0] rd2_s0, rd2_s1, rd1_s0;

    function automatic logic [DW-1:0] seed_word(int sel, int i);
        return (32'(i) * 32'h9E37_79B1) ^ (32'(sel) << 28);
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) bram2[i] <= seed_word(2, i);
        end else if (m2_en) begin
            if (m2_we) bram2[m2_addr] <= m2_din;
            else       rd2_s0 <= bram2[m2_addr];
        end
        if (m2_rst)        rd2_s1 <= '0;
        else if (m2_regce) rd2_s1 <= rd2_s0;
    end
    assign m2_dout = rd2_s1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) bram1[i] <= seed_word(1, i);
        end else if (m1_en) begin
            if (m1_we) bram1[m1_addr] <= m1_din;
            else       rd1_s0 <= bram1[m1_addr];
        end
    end
    assign m1_dout = rd1_s0;

    // ---------------- view of the selected controller ----------------
    logic          v_ready, v_resp_valid, v_busy, v_en, v_we;
    logic [9:0]    v_addr;
    logic [DW-1:0] v_din;
    line_t         v_rdata;

    assign v_ready      = (cur == 2) ? bus2.req_ready  : bus1.req_ready;
    assign v_resp_valid = (cur == 2) ? bus2.resp_valid : bus1.resp_valid;
    assign v_busy       = (cur == 2) ? bus2.busy       : bus1.busy;
    assign v_rdata      = (cur == 2) ? bus2.resp_rdata : bus1.resp_rdata;
    assign v_en         = (cur == 2) ? m2_en   : m1_en;
    assign v_we         = (cur == 2) ? m2_we   : m1_we;
    assign v_addr       = (cur == 2) ? m2_addr : m1_addr;
    assign v_din        = (cur == 2) ? m2_din  : m1_din;

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [1:2][1024];
    line_t         last_rd [1:2];

    // Line base word address: byte address / 4, truncated to the BRAM range,
    // rounded down to a whole line.
    function automatic logic [9:0] line_base(logic [31:0] a);
        return 10'((a >> 2) & 32'h0000_03FC);
    endfunction

    function automatic line_t ref_line(int sel, logic [9:0] b);
        line_t l;
        for (int i = 0; i < LW; i++) l[i*DW +: DW] = ref_mem[sel][b + 10'(i)];
        return l;
    endfunction

    task automatic ref_write(input int sel, input logic [9:0] b, input line_t w);
        for (int i = 0; i < LW; i++) ref_mem[sel][b + 10'(i)] = w[i*DW +: DW];
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [LW*DW-1:0] act,
                         input logic [LW*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with req_valid already high; returns in the
    // accepting cycle T (ready seen while valid is high).
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (v_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_seen", ok, 1'b1);
    endtask

    // Walks cycles T+1..T+exp_resp checking the BRAM port and handshake.
    // Request inputs are scrambled after acceptance to prove they are latched.
    task automatic track_xfer(input bit we, input logic [9:0] b, input line_t w,
                              input int exp_resp, input bit drop);
        for (int k = 1; k <= exp_resp; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (drop) req_valid = 1'b0;
                req_addr  = $urandom;
                req_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (k <= LW) begin
                check("mem_en", v_en, 1'b1);
                check("mem_we", v_we, we);
                check("mem_addr", v_addr, b + 10'(k - 1));
                if (we) check("mem_din", v_din, w[(k-1)*DW +: DW]);
            end else begin
                check("mem_en_idle", v_en, 1'b0);
                check("mem_we_idle", v_we, 1'b0);
            end
            check("resp_valid", v_resp_valid, k == exp_resp);
            check("req_ready_busy", v_ready, 1'b0);
            check("busy", v_busy, k != exp_resp);
        end
    endtask

    task automatic do_req(input int sel, input bit we, input logic [31:0] addr,
                          input line_t w, input logic [9:0] exp_base,
                          input int exp_resp, input line_t exp_rd);
        bit ok;
        cur       = sel;
        req_we    = we;
        req_addr  = addr;
        req_wdata = w;
        req_valid = 1'b1;
        wait_accept(ok);
        if (!ok) begin
            req_valid = 1'b0;
            return;
        end
        if (we) ref_write(sel, exp_base, w);
        track_xfer(we, exp_base, w, exp_resp, 1'b1);
        if (we) begin
            check("rdata_kept", v_rdata, last_rd[sel]);
        end else begin
            check("resp_rdata", v_rdata, exp_rd);
            last_rd[sel] = exp_rd;
        end
    endtask

    // ---------------- stimulus ----------------
    vec_t  vecs[5];
    line_t l_a, l_b, l_c;

    initial begin
        bit          ok;
        int          sel;
        bit          we;
        logic [31:0] addr;
        line_t       w;
        logic [9:0]  b;

        l_a = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        l_b = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
        l_c = {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h1234_5678, 32'hDEAD_BEEF};

        vecs[0] = '{sel: 2, we: 1'b1, addr: 32'h0000_0100, wdata: l_a, exp_base: 10'h040, exp_resp: 5, exp_rdata: '0};
        vecs[1] = '{sel: 2, we: 1'b0, addr: 32'h0000_0100, wdata: '0,  exp_base: 10'h040, exp_resp: 7, exp_rdata: l_a};
        vecs[2] = '{sel: 2, we: 1'b0, addr: 32'h0000_110C, wdata: '0,  exp_base: 10'h040, exp_resp: 7, exp_rdata: l_a};
        vecs[3] = '{sel: 1, we: 1'b1, addr: 32'h0000_0100, wdata: l_a, exp_base: 10'h040, exp_resp: 5, exp_rdata: '0};
        vecs[4] = '{sel: 1, we: 1'b0, addr: 32'h0000_110C, wdata: '0,  exp_base: 10'h040, exp_resp: 6, exp_rdata: l_a};

        for (int s = 1; s <= 2; s++) begin
            for (int i = 0; i < 1024; i++) ref_mem[s][i] = seed_word(s, i);
            last_rd[s] = '0;
        end

        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        // 1. reset for three cycles
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst     = 1'b0;
        check("rst_ready2", bus2.req_ready, 1'b1);
        check("rst_busy2", bus2.busy, 1'b0);
        check("rst_resp_valid2", bus2.resp_valid, 1'b0);
        check("rst_resp_rdata2", bus2.resp_rdata, '0);
        check("rst_mem_en2", m2_en, 1'b0);
        check("rst_mem_we2", m2_we, 1'b0);
        check("rst_mem_addr2", m2_addr, '0);
        check("rst_mem_din2", m2_din, '0);
        check("rst_mem_rst2", m2_rst, 1'b0);
        check("rst_mem_regce2", m2_regce, 1'b1);
        check("rst_ready1", bus1.req_ready, 1'b1);
        check("rst_mem_en1", m1_en, 1'b0);
        check("rst_resp_rdata1", bus1.resp_rdata, '0);
        check("rst_mem_regce1", m1_regce, 1'b1);

        // 2-4. directed vectors
        for (int i = 0; i < 5; i++) begin
            do_req(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_base, vecs[i].exp_resp, vecs[i].exp_rdata);
        end

        // 5. back-to-back: valid held, write then read of 0x300
        @(negedge clk);
        cur       = 2;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0300;
        req_wdata = l_b;
        req_valid = 1'b1;
        wait_accept(ok);
        ref_write(2, 10'h0C0, l_b);
        track_xfer(1'b1, 10'h0C0, l_b, 5, 1'b0);
        check("b2b_rdata_kept", v_rdata, last_rd[2]);
        req_we   = 1'b0;
        req_addr = 32'h0000_0300;
        @(negedge clk);
        #1;
        check("b2b_accept_at_resp_plus1", v_ready, 1'b1);
        track_xfer(1'b0, 10'h0C0, '0, 7, 1'b1);
        check("b2b_rdata", v_rdata, l_b);
        last_rd[2] = l_b;

        // 6. reset in the middle of a refill
        @(negedge clk);
        do_req(2, 1'b1, 32'h0000_0200, l_c, 10'h080, 5, '0);
        cur       = 2;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0100;
        req_valid = 1'b1;
        wait_accept(ok);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_en", v_en, 1'b0);
        check("abort_resp_valid", v_resp_valid, 1'b0);
        check("abort_busy", v_busy, 1'b0);
        check("abort_ready", v_ready, 1'b1);
        check("abort_mem_addr", v_addr, '0);
        check("abort_resp_rdata", v_rdata, '0);
        rst        = 1'b0;
        last_rd[1] = '0;
        last_rd[2] = '0;
        do_req(2, 1'b0, 32'h0000_0200, '0, 10'h080, 7, l_c);

        // random traffic against the reference memories
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel        = ($urandom_range(0, 1) == 1) ? 2 : 1;
            we         = 1'($urandom_range(0, 1));
            addr       = $urandom;
            addr[11:4] = 8'($urandom_range(0, 7));
            w          = {$urandom, $urandom, $urandom, $urandom};
            b          = line_base(addr);
            do_req(sel, we, addr, w, b,
                   LW + 1 + (we ? 0 : ((sel == 2) ? 2 : 1)),
                   we ? '0 : ref_line(sel, b));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1);
    end

endmodule
